imm_gen_pipe: RTL and testbench

//  Parametrised successor to signextend: decodes the immediate of any RV32I/RV64I instruction word
//  (I, S, B, U, J formats) and sign-extends it to XLEN bits.

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/imm_decode.sv | 51 +++++
 rtl/imm_gen_pipe.sv | 96 +++++++++
 tb/tb_imm_gen_pipe.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode types: immediate format codes, base opcodes and the canonical NOP.
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_t;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: instruction word -> format code and XLEN sign-extended immediate.
module imm_decode
  import riscv_pkg::*;
#(
  parameter int XLEN = 64,
  parameter bit RV64 = 1'b1
) (
  input  logic [31:0]     instr,
  output imm_fmt_t        fmt,
  output logic [XLEN-1:0] imm
);

  logic signed [31:0] imm32;

  always_comb begin
    fmt   = FMT_NONE;
    imm32 = '0;
    case (instr[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM: begin
        fmt   = FMT_I;
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_OPIMM32: begin
        if (RV64) begin
          fmt   = FMT_I;
          imm32 = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OPC_STORE: begin
        fmt   = FMT_S;
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        fmt   = FMT_B;
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt   = FMT_U;
        imm32 = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        fmt   = FMT_J;
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: ;
    endcase
    // Signed size cast widens from bit 31 on RV64 and is a no-op at XLEN=32.
    imm = XLEN'(imm32);
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate-decode stage with a 2-entry FIFO buffer, valid/ready on both sides and flush.
module imm_gen_pipe
  import riscv_pkg::*;
#(
  parameter int XLEN = 64,
  parameter bit RV64 = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output imm_fmt_t        out_fmt,
  output logic [31:0]     out_instr
);

  imm_fmt_t        dec_fmt;
  logic [XLEN-1:0] dec_imm;

  imm_decode #(.XLEN(XLEN), .RV64(RV64)) u_dec (
    .instr (in_instr),
    .fmt   (dec_fmt),
    .imm   (dec_imm)
  );

  // Entry 0 is always the head; entry 1 only holds data when count is 2.
  logic [1:0]      count_q, count_d;
  logic [XLEN-1:0] imm_q   [2];
  logic [XLEN-1:0] imm_d   [2];
  imm_fmt_t        fmt_q   [2];
  imm_fmt_t        fmt_d   [2];
  logic [31:0]     instr_q [2];
  logic [31:0]     instr_d [2];
  logic            push, pop;

  assign in_ready  = (count_q != 2'd2) && !rst;
  assign out_valid = (count_q != 2'd0);
  assign out_imm   = imm_q[0];
  assign out_fmt   = fmt_q[0];
  assign out_instr = instr_q[0];

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    imm_d   = imm_q;
    fmt_d   = fmt_q;
    instr_d = instr_q;
    if (flush) begin
      count_d = 2'd0;
    end else if (push && pop) begin
      // Only reachable at count 1: replace the head in place.
      imm_d[0]   = dec_imm;
      fmt_d[0]   = dec_fmt;
      instr_d[0] = in_instr;
    end else if (pop) begin
      imm_d[0]   = imm_q[1];
      fmt_d[0]   = fmt_q[1];
      instr_d[0] = instr_q[1];
      count_d    = count_q - 2'd1;
    end else if (push) begin
      if (count_q == 2'd0) begin
        imm_d[0]   = dec_imm;
        fmt_d[0]   = dec_fmt;
        instr_d[0] = in_instr;
      end else begin
        imm_d[1]   = dec_imm;
        fmt_d[1]   = dec_fmt;
        instr_d[1] = in_instr;
      end
      count_d = count_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        imm_q[i]   <= '0;
        fmt_q[i]   <= FMT_NONE;
        instr_q[i] <= NOP_INSTR;
      end
    end else begin
      count_q <= count_d;
      imm_q   <= imm_d;
      fmt_q   <= fmt_d;
      instr_q <= instr_d;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomised scoreboard bench for imm_gen_pipe (XLEN=64, RV64=1) plus directed handshake cases.
module tb_imm_gen_pipe;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_instr = 32'h0;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_imm;
  imm_fmt_t    out_fmt;
  logic [31:0] out_instr;

  imm_gen_pipe #(.XLEN(64), .RV64(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_fmt   (out_fmt),
    .out_instr (out_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [63:0] v;
    logic [31:0] w;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: immediate value as a signed integer assembled from instruction fields.
  function automatic exp_t model(input logic [31:0] w);
    exp_t   e;
    longint s;
    e.w = w;
    e.f = 3'd0;
    s   = 0;
    case (w[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67, 7'h73: begin
        e.f = 3'd1;
        s = longint'(w[31:20]);
        if (w[31]) s = s - 4096;
      end
      7'h23: begin
        e.f = 3'd2;
        s = longint'(w[31:25]) * 32 + longint'(w[11:7]);
        if (w[31]) s = s - 4096;
      end
      7'h63: begin
        e.f = 3'd3;
        s = longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
        if (w[31]) s = s - 4096;
      end
      7'h37, 7'h17: begin
        e.f = 3'd4;
        s = longint'(w[31:12]) * 4096;
        if (w[31]) s = s - 64'sd4294967296;
      end
      7'h6F: begin
        e.f = 3'd5;
        s = longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
        if (w[31]) s = s - 1048576;
      end
      default: s = 0;
    endcase
    e.v = 64'(s);
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int          k;
    w = $urandom;
    k = $urandom_range(0, 12);
    case (k)
      0: w[6:0] = 7'h03;   1: w[6:0] = 7'h13;   2: w[6:0] = 7'h1B;
      3: w[6:0] = 7'h67;   4: w[6:0] = 7'h73;   5: w[6:0] = 7'h23;
      6: w[6:0] = 7'h63;   7: w[6:0] = 7'h37;   8: w[6:0] = 7'h17;
      9: w[6:0] = 7'h6F;  10: w[6:0] = 7'h33;  11: w[6:0] = 7'h7F;
      default: ;
    endcase
    return w;
  endfunction

  // Monitor: samples mid-cycle what will transfer at the coming rising edge.
  always @(negedge clk) begin
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 64'(out_instr), 64'hDEAD);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_fmt", 64'(out_fmt), 64'(e.f));
          chk("sb_imm", out_imm, e.v);
          chk("sb_instr", 64'(out_instr), 64'(e.w));
        end
      end
      if (in_valid && in_ready) sb.push_back(model(in_instr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    int i;
    in_valid = 1'b1;
    in_instr = w;
    i = 0;
    while (!in_ready && i < 50) begin
      tick();
      i++;
    end
    if (!in_ready) chk("send_timeout", 64'(in_ready), 64'h1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1);
  end

  logic [31:0] dir_w [6];
  logic [2:0]  dir_f [6];
  logic [63:0] dir_v [6];
  logic [31:0] w0, w1, w2;

  initial begin
    dir_w[0] = 32'hFFFF_FFFF; dir_f[0] = 3'd0; dir_v[0] = 64'h0;
    dir_w[1] = {12'b010000100011, 5'b10101, 3'b010, 5'b01010, 7'b0000011};
    dir_f[1] = 3'd1; dir_v[1] = 64'h0000_0000_0000_0423;
    dir_w[2] = {7'b0100001, 5'b00011, 5'b10101, 3'b010, 5'b10001, 7'b0100011};
    dir_f[2] = 3'd2; dir_v[2] = 64'h0000_0000_0000_0431;
    dir_w[3] = {7'b1100001, 5'b00011, 5'b10101, 3'b010, 5'b01110, 7'b1100011};
    dir_f[3] = 3'd3; dir_v[3] = 64'hFFFF_FFFF_FFFF_F42E;
    dir_w[4] = 32'h8000_00B7; dir_f[4] = 3'd4; dir_v[4] = 64'hFFFF_FFFF_8000_0000;
    dir_w[5] = 32'h8000_006F; dir_f[5] = 3'd5; dir_v[5] = 64'hFFFF_FFFF_FFF0_0000;

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_instr", 64'(out_instr), 64'h13);
    chk("rst_out_imm", out_imm, 64'h0);
    chk("rst_out_fmt", 64'(out_fmt), 64'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 64'(in_ready), 64'h1);

    // Directed decodes, one word at a time into an empty buffer: visible right after acceptance.
    for (int i = 0; i < 6; i++) begin
      send(dir_w[i]);
      chk("dir_valid", 64'(out_valid), 64'h1);
      chk("dir_fmt", 64'(out_fmt), 64'(dir_f[i]));
      chk("dir_imm", out_imm, dir_v[i]);
      tick();
    end
    drain();

    // Back-pressure: third word refused, head stable, then both emerge in order.
    w0 = rand_instr(); w1 = rand_instr(); w2 = rand_instr();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = w0; tick();
    in_instr  = w1; tick();
    in_instr  = w2;
    chk("bp_in_ready_full", 64'(in_ready), 64'h0);
    chk("bp_head", 64'(out_instr), 64'(w0));
    tick();
    chk("bp_head_stable", 64'(out_instr), 64'(w0));
    chk("bp_valid_held", 64'(out_valid), 64'h1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_second", 64'(out_instr), 64'(w1));
    tick();
    chk("bp_empty", 64'(out_valid), 64'h0);
    chk("bp_in_ready_again", 64'(in_ready), 64'h1);
    drain();

    // Flush with two entries held and a word offered in the flush cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = rand_instr(); tick();
    in_instr  = rand_instr(); tick();
    flush     = 1'b1;
    out_ready = 1'b1;
    in_instr  = rand_instr();
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'h0);
    drain();

    // Reset with two entries held.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = rand_instr(); tick();
    in_instr  = rand_instr(); tick();
    rst = 1'b1;
    chk("midrst_in_ready", 64'(in_ready), 64'h0);
    tick();
    chk("midrst_out_valid", 64'(out_valid), 64'h0);
    chk("midrst_out_instr", 64'(out_instr), 64'h13);
    chk("midrst_out_imm", out_imm, 64'h0);
    rst      = 1'b0;
    in_valid = 1'b0;
    drain();

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      in_instr  = rand_instr();
      tick();
    end
    // Full-throughput burst.
    out_ready = 1'b1;
    flush     = 1'b0;
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'b1;
      in_instr = rand_instr();
      chk("stream_in_ready", 64'(in_ready), 64'h1);
      tick();
    end
    drain();
    chk("sb_drained", 64'(sb.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
